// File: rtl/pdm_decimator.sv
// PDM receive path: bit-clock generator, 2-flop input sync, 3rd-order CIC decimator, scale and saturate.
// Define PDM_DC_BLOCK_EN to append a first-order DC-blocking high-pass (adds one cycle of latency).
module pdm_decimator #(
    parameter int CLK_DIV    = 25,
    parameter int DECIM_LOG2 = 6,
    parameter int OUT_W      = 18
) (
    input  logic             clk_in,
    input  logic             rst_in,
    input  logic             pdm_data_in,
    output logic             pdm_clk_out,
    output logic [OUT_W-1:0] sample_out,
    output logic             sample_valid
);

    localparam int ACC_W   = 2 + 3 * DECIM_LOG2;
    localparam int SHIFT   = 3 * DECIM_LOG2 - OUT_W + 1;
    localparam int DIV_W   = $clog2(CLK_DIV);
    localparam int SAT_MAX = (1 << (OUT_W - 1)) - 1;
    localparam int SAT_MIN = -(1 << (OUT_W - 1));

    function automatic logic [OUT_W-1:0] saturate(input logic signed [31:0] v);
        logic [OUT_W-1:0] r;
        if (v > SAT_MAX) begin
            r = OUT_W'(SAT_MAX);
        end else if (v < SAT_MIN) begin
            r = OUT_W'(SAT_MIN);
        end else begin
            r = v[OUT_W-1:0];
        end
        return r;
    endfunction

    logic [DIV_W-1:0]      div_cnt_q;
    logic                  pdm_clk_q;
    logic                  div_wrap;
    logic                  strobe;
    logic [1:0]            sync_q;
    logic [DECIM_LOG2-1:0] decim_cnt_q;
    logic                  latch_q;
    logic [ACC_W-1:0]      pdm_val;

    // Bit is captured on the cycle the PDM clock is about to fall.
    assign div_wrap = (div_cnt_q == DIV_W'(CLK_DIV - 1));
    assign strobe   = div_wrap & pdm_clk_q;
    assign pdm_val  = {{(ACC_W-1){~sync_q[1]}}, 1'b1};

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            div_cnt_q   <= '0;
            pdm_clk_q   <= 1'b0;
            sync_q      <= '0;
            decim_cnt_q <= '0;
            latch_q     <= 1'b0;
        end else begin
            sync_q  <= {sync_q[0], pdm_data_in};
            latch_q <= strobe && (decim_cnt_q == {DECIM_LOG2{1'b1}});
            if (div_wrap) begin
                div_cnt_q <= '0;
                pdm_clk_q <= ~pdm_clk_q;
            end else begin
                div_cnt_q <= div_cnt_q + 1'b1;
            end
            if (strobe) begin
                decim_cnt_q <= decim_cnt_q + 1'b1;
            end
        end
    end

    // Integrators are pipelined (each adds the previous stage's registered value) and wrap freely.
    genvar gi;
    generate
        for (gi = 0; gi < 3; gi++) begin : g_int
            logic [ACC_W-1:0] acc_in;
            logic [ACC_W-1:0] acc_q;
            logic [ACC_W-1:0] acc_d;
            if (gi == 0) begin : g_src
                assign acc_in = pdm_val;
            end else begin : g_src
                assign acc_in = g_int[gi-1].acc_q;
            end
            assign acc_d = acc_q + acc_in;
            always_ff @(posedge clk_in) begin
                if (rst_in) begin
                    acc_q <= '0;
                end else if (strobe) begin
                    acc_q <= acc_d;
                end
            end
        end

        for (gi = 0; gi < 3; gi++) begin : g_comb
            logic [ACC_W-1:0] x_in;
            logic [ACC_W-1:0] y;
            logic [ACC_W-1:0] dly_q;
            if (gi == 0) begin : g_src
                assign x_in = g_int[2].acc_q;
            end else begin : g_src
                assign x_in = g_comb[gi-1].y;
            end
            assign y = x_in - dly_q;
            always_ff @(posedge clk_in) begin
                if (rst_in) begin
                    dly_q <= '0;
                end else if (latch_q) begin
                    dly_q <= x_in;
                end
            end
        end
    endgenerate

    logic signed [ACC_W-1:0] scaled;
    logic [OUT_W-1:0]        cic_sat;
    logic [OUT_W-1:0]        sample_q;
    logic                    valid_q;

    assign scaled  = $signed(g_comb[2].y) >>> SHIFT;
    assign cic_sat = saturate(32'(scaled));

`ifdef PDM_DC_BLOCK_EN
    localparam int DC_W = 20;

    logic [OUT_W-1:0]       cic_q;
    logic                   cic_valid_q;
    logic signed [DC_W-1:0] dc_x;
    logic signed [DC_W-1:0] dc_x_prev_q;
    logic signed [DC_W-1:0] dc_y_q;
    logic signed [DC_W-1:0] dc_y_d;

    // Leaky differentiator: pole at 1 - 2^-10 removes DC with a very slow settle.
    assign dc_x   = DC_W'($signed(cic_q));
    assign dc_y_d = dc_x - dc_x_prev_q + dc_y_q - (dc_y_q >>> 10);

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            cic_q       <= '0;
            cic_valid_q <= 1'b0;
            dc_x_prev_q <= '0;
            dc_y_q      <= '0;
            sample_q    <= '0;
            valid_q     <= 1'b0;
        end else begin
            cic_valid_q <= latch_q;
            valid_q     <= cic_valid_q;
            if (latch_q) begin
                cic_q <= cic_sat;
            end
            if (cic_valid_q) begin
                dc_x_prev_q <= dc_x;
                dc_y_q      <= dc_y_d;
                sample_q    <= saturate(32'(dc_y_d));
            end
        end
    end
`else
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            sample_q <= '0;
            valid_q  <= 1'b0;
        end else begin
            valid_q <= latch_q;
            if (latch_q) begin
                sample_q <= cic_sat;
            end
        end
    end
`endif

    assign pdm_clk_out  = pdm_clk_q;
    assign sample_out   = sample_q;
    assign sample_valid = valid_q;

endmodule

// File: tb/tb_pdm_decimator.sv
// Scoreboard bench for pdm_decimator: stimulus queues expected samples, a monitor checks each valid strobe.
module tb_pdm_decimator;

    localparam int OUT_W = 18;
    localparam int FRAME = 3200;
`ifdef PDM_DC_BLOCK_EN
    localparam int LAT = 3;
`else
    localparam int LAT = 2;
`endif

    logic             clk_in = 1'b0;
    logic             rst_in = 1'b1;
    logic             pdm_data_in;
    logic             pdm_clk_out;
    logic [OUT_W-1:0] sample_out;
    logic             sample_valid;

    typedef struct {
        int mode;   // 0 = ignore value, 1 = equal, 2 = at least
        int id;
        int val;
    } exp_t;

    exp_t       sb_q[$];
    int         n_cmp = 0;
    int         n_bad = 0;
    logic [3:0] pat_bits = 4'b0001;
    int         pat_len = 1;

    pdm_decimator dut (
        .clk_in       (clk_in),
        .rst_in       (rst_in),
        .pdm_data_in  (pdm_data_in),
        .pdm_clk_out  (pdm_clk_out),
        .sample_out   (sample_out),
        .sample_valid (sample_valid)
    );

    initial begin
        forever #5 clk_in = ~clk_in;
    end

    task automatic check(input string name, input int got, input int exp);
        n_cmp++;
        if (got != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", name, got, exp);
        end
    endtask

    task automatic push(input int mode, input int id, input int val);
        exp_t e;
        e.mode = mode;
        e.id   = id;
        e.val  = val;
        sb_q.push_back(e);
    endtask

    // Three CIC fill transients, then two settled samples.
    task automatic push_frames(input int id, input int mode, input int val);
        for (int i = 0; i < 3; i++) push(0, id, 0);
        push(mode, id, val);
        push(mode, id, val);
    endtask

    task automatic reset_dut(input logic [3:0] bits, input int len);
        @(negedge clk_in);
        rst_in   = 1'b1;
        pat_bits = bits;
        pat_len  = len;
        repeat (10) @(negedge clk_in);
        check("rst_sample", int'($signed(sample_out)), 0);
        check("rst_valid", int'(sample_valid), 0);
        check("rst_pdm_clk", int'(pdm_clk_out), 0);
        rst_in = 1'b0;
    endtask

    task automatic wait_drain(input string name, input int budget);
        int n = 0;
        while (sb_q.size() != 0 && n < budget) begin
            @(negedge clk_in);
            n++;
        end
        check({name, "_pending"}, sb_q.size(), 0);
        sb_q.delete();
    endtask

    task automatic count_falls(input int target, input int budget, output bit ok);
        int   falls = 0;
        int   n = 0;
        logic prev = pdm_clk_out;
        while (falls < target && n < budget) begin
            @(negedge clk_in);
            n++;
            if (prev && !pdm_clk_out) falls++;
            prev = pdm_clk_out;
        end
        ok = (falls == target);
    endtask

    // PDM source: new bit on each rising PDM clock.
    initial begin : pdm_source
        int n;
        n = 0;
        pdm_data_in = 1'b0;
        forever begin
            @(posedge pdm_clk_out);
            pdm_data_in = pat_bits[n % pat_len];
            n++;
        end
    end

    initial begin : monitor
        exp_t   e;
        bit     prev_v;
        bit     have_last;
        longint last_t;
        int     got;
        prev_v    = 1'b0;
        have_last = 1'b0;
        last_t    = 0;
        forever begin
            @(negedge clk_in);
            if (rst_in) begin
                prev_v    = 1'b0;
                have_last = 1'b0;
            end else if (sample_valid) begin
                got = int'($signed(sample_out));
                check("valid_width", int'(prev_v), 0);
                if (have_last) check("valid_spacing", int'(($time - last_t) / 10), FRAME);
                check("valid_expected", int'(sb_q.size() > 0), 1);
                if (sb_q.size() > 0) begin
                    e = sb_q.pop_front();
                    $display("sample test=%0d t=%0t value=%0d mode=%0d ref=%0d", e.id, $time, got, e.mode, e.val);
                    if (e.mode == 1) begin
                        check($sformatf("sample_t%0d", e.id), got, e.val);
                    end else if (e.mode == 2) begin
                        n_cmp++;
                        if (got < e.val) begin
                            n_bad++;
                            $display("FAIL sample_t%0d_min: got %0d, required >= %0d", e.id, got, e.val);
                        end
                    end
                end
                last_t    = $time;
                have_last = 1'b1;
                prev_v    = 1'b1;
            end else begin
                prev_v = 1'b0;
            end
        end
    end

    initial begin : stim
        bit ok;

        // Reset values, then PDM clock waveform with constant-1 input.
        reset_dut(4'b0001, 1);
`ifdef PDM_DC_BLOCK_EN
        for (int i = 0; i < 3; i++) push(0, 1, 0);
        push(2, 1, 130000);
        push(0, 1, 0);
`else
        push_frames(1, 1, 131071);
`endif
        for (int k = 1; k <= 100; k++) begin
            @(negedge clk_in);
            check("pdm_clk_wave", int'(pdm_clk_out), (k / 25) % 2);
        end
        wait_drain("const1", 5 * FRAME + 200);

`ifdef PDM_DC_BLOCK_EN
        reset_dut(4'b0000, 1);
        push_frames(2, 0, 0);
        wait_drain("const0", 5 * FRAME + 200);
        reset_dut(4'b0001, 2);
        push_frames(3, 0, 0);
        wait_drain("alt10", 5 * FRAME + 200);
        reset_dut(4'b0111, 4);
        push_frames(4, 0, 0);
        wait_drain("pat1110", 5 * FRAME + 200);
`else
        reset_dut(4'b0000, 1);
        push_frames(2, 1, -131072);
        wait_drain("const0", 5 * FRAME + 200);
        reset_dut(4'b0001, 2);
        push_frames(3, 1, 0);
        wait_drain("alt10", 5 * FRAME + 200);
        reset_dut(4'b0111, 4);
        push_frames(4, 1, 65536);
        wait_drain("pat1110", 5 * FRAME + 200);
`endif

        // Reset one cycle after the 30th strobe: that frame must vanish.
        reset_dut(4'b0001, 1);
        count_falls(30, 3100, ok);
        check("falls_before_rst", int'(ok), 1);
        rst_in = 1'b1;
        repeat (3) @(negedge clk_in);
        rst_in = 1'b0;
        push(0, 5, 0);
        count_falls(64, 6500, ok);
        check("falls_after_rst", int'(ok), 1);
        check("valid_before_lat", int'(sample_valid), 0);
        repeat (LAT - 1) @(negedge clk_in);
        check("valid_at_lat", int'(sample_valid), 1);
        wait_drain("midrst", 100);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin : watchdog
        #950000;
        $display("FAIL watchdog: simulation time limit reached, got no summary, required completion");
        $fatal(1, "watchdog expired");
    end

endmodule
